// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory stage of the pipeline. It consumes the EX/MEM register and runs a
// req/gnt/rvalid handshake with the data memory. It aligns and extends load
// data, stalls the upstream stages while an access is outstanding, and
// registers the MEM/WB outputs.
//
// Ports
//   clk, reset                 pipeline clock, async active-high reset
//   memread_MEM/memwrite_MEM   load / store in MEM (read wins if both set)
//   regwrite_MEM, rd_MEM       write-back enable and destination
//   ALU_data_MEM               ALU result, byte address for loads/stores
//   store_data_MEM             store data (rs2)
//   funct3_MEM                 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   dmem_*                     data memory request/response channel
//   stall_MEM                  freeze IF..EX/MEM while an access is pending
//   misalign_MEM               misaligned H/W access (no request issued)
//   regwrite_WB, rd_WB, wb_data_WB  registered MEM/WB outputs
module mem_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread_MEM,
  input  logic        memwrite_MEM,
  input  logic        regwrite_MEM,
  input  logic [4:0]  rd_MEM,
  input  logic [31:0] ALU_data_MEM,
  input  logic [31:0] store_data_MEM,
  input  logic [2:0]  funct3_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_MEM,
  output logic        misalign_MEM,
  output logic        regwrite_WB,
  output logic [4:0]  rd_WB,
  output logic [31:0] wb_data_WB
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        is_read, is_write, misalign, access;
  logic        req, stall;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  // Access classification and alignment check (funct3[1:0] carries the size)
  always_comb begin
    is_read  = memread_MEM;
    is_write = memwrite_MEM & ~memread_MEM;
    case (funct3_MEM[1:0])
      2'b01:   misalign = (memread_MEM | memwrite_MEM) & ALU_data_MEM[0];
      2'b10:   misalign = (memread_MEM | memwrite_MEM) & (ALU_data_MEM[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
    access = (memread_MEM | memwrite_MEM) & ~misalign;
  end

  // Byte enables and lane-replicated store data; loads use the same enables
  always_comb begin
    dmem_addr = {ALU_data_MEM[31:2], 2'b00};
    case (funct3_MEM[1:0])
      2'b00: begin
        dmem_be    = 4'b0001 << ALU_data_MEM[1:0];
        dmem_wdata = {4{store_data_MEM[7:0]}};
      end
      2'b01: begin
        dmem_be    = 4'b0011 << ALU_data_MEM[1:0];
        dmem_wdata = {2{store_data_MEM[15:0]}};
      end
      2'b10: begin
        dmem_be    = 4'b1111;
        dmem_wdata = store_data_MEM;
      end
      default: begin
        dmem_be    = 4'b0000;
        dmem_wdata = store_data_MEM;
      end
    endcase
  end

  // Load lane select and sign/zero extension
  always_comb begin
    case (ALU_data_MEM[1:0])
      2'b00:   load_byte = dmem_rdata[7:0];
      2'b01:   load_byte = dmem_rdata[15:8];
      2'b10:   load_byte = dmem_rdata[23:16];
      2'b11:   load_byte = dmem_rdata[31:24];
      default: load_byte = dmem_rdata[7:0];
    endcase
    if (ALU_data_MEM[1]) begin
      load_half = dmem_rdata[31:16];
    end else begin
      load_half = dmem_rdata[15:0];
    end
    case (funct3_MEM)
      3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_ext = {{16{load_half[15]}}, load_half};
      3'b100:  load_ext = {24'h000000, load_byte};
      3'b101:  load_ext = {16'h0000, load_half};
      default: load_ext = dmem_rdata;
    endcase
  end

  // Handshake FSM: a granted read moves to WAIT; rvalid is only seen in WAIT
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req   = access;
        // a granted store finishes this cycle, anything else still pending stalls
        stall = access & ~(dmem_gnt & is_write);
        if (access & dmem_gnt & is_read) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        stall = ~dmem_rvalid;
        if (dmem_rvalid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // MEM/WB next values: a stall inserts a bubble and holds rd/data
  always_comb begin
    if (stall) begin
      regwrite_d = 1'b0;
      rd_d       = rd_q;
      wb_data_d  = wb_data_q;
    end else begin
      regwrite_d = regwrite_MEM & ~misalign;
      rd_d       = rd_MEM;
      if (memread_MEM) begin
        wb_data_d = load_ext;
      end else begin
        wb_data_d = ALU_data_MEM;
      end
    end
  end

  // State and MEM/WB registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      regwrite_q <= 1'b0;
      rd_q       <= 5'd0;
      wb_data_q  <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign dmem_we      = is_write;
  assign dmem_req     = req & ~reset;
  assign stall_MEM    = stall & ~reset;
  assign misalign_MEM = misalign & ~reset;
  assign regwrite_WB  = regwrite_q;
  assign rd_WB        = rd_q;
  assign wb_data_WB   = wb_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage. Inputs change 1 time unit
// after a rising edge. Combinational outputs are sampled on the falling edge,
// and registered outputs 1 time unit after the next rising edge.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread_MEM, memwrite_MEM, regwrite_MEM;
  logic [4:0]  rd_MEM;
  logic [31:0] ALU_data_MEM, store_data_MEM;
  logic [2:0]  funct3_MEM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall_MEM, misalign_MEM, regwrite_WB;
  logic [4:0]  rd_WB;
  logic [31:0] wb_data_WB;

  int vectors = 0;
  int miscompares = 0;

  mem_access_stage dut (
    .clk(clk), .reset(reset),
    .memread_MEM(memread_MEM), .memwrite_MEM(memwrite_MEM),
    .regwrite_MEM(regwrite_MEM), .rd_MEM(rd_MEM),
    .ALU_data_MEM(ALU_data_MEM), .store_data_MEM(store_data_MEM),
    .funct3_MEM(funct3_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall_MEM(stall_MEM), .misalign_MEM(misalign_MEM),
    .regwrite_WB(regwrite_WB), .rd_WB(rd_WB), .wb_data_WB(wb_data_WB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic mw, input logic rw,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [2:0] f3);
    memread_MEM = mr; memwrite_MEM = mw; regwrite_MEM = rw;
    rd_MEM = rd; ALU_data_MEM = alu; store_data_MEM = sd; funct3_MEM = f3;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'b000);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- reset: outputs forced low even with a load presented and gnt high
    reset = 1'b1; dmem_gnt = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    drive(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0200, 32'h0, 3'b010);
    @(negedge clk);
    chk("rst_req", dmem_req, 32'd0);
    chk("rst_stall", stall_MEM, 32'd0);
    chk("rst_regwrite_wb", regwrite_WB, 32'd0);
    chk("rst_rd_wb", rd_WB, 32'd0);
    chk("rst_wb_data", wb_data_WB, 32'd0);
    ALU_data_MEM = 32'h0000_0202;
    #1;
    chk("rst_misalign", misalign_MEM, 32'd0);
    cyc();
    reset = 1'b0; dmem_gnt = 1'b0; nop();

    // ---- ALU op: 1-cycle latency, no stall
    cyc();
    drive(1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 3'b000);
    @(negedge clk);
    chk("alu_stall", stall_MEM, 32'd0);
    chk("alu_req", dmem_req, 32'd0);
    cyc();
    chk("alu_regwrite_wb", regwrite_WB, 32'd1);
    chk("alu_rd_wb", rd_WB, 32'd5);
    chk("alu_wb_data", wb_data_WB, 32'h0000_1234);

    // ---- SB at 0x103 with zero-wait gnt
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0103, 32'h0000_00AB, 3'b000);
    dmem_gnt = 1'b1;
    @(negedge clk);
    chk("sb_req", dmem_req, 32'd1);
    chk("sb_we", dmem_we, 32'd1);
    chk("sb_be", dmem_be, 32'b1000);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    chk("sb_addr", dmem_addr, 32'h0000_0100);
    chk("sb_stall", stall_MEM, 32'd0);
    cyc();
    chk("sb_regwrite_wb", regwrite_WB, 32'd0);

    // ---- LB at 0x102: gnt in cycle 0, rvalid in cycle 3
    drive(1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0102, 32'h0, 3'b000);
    dmem_gnt = 1'b1;
    @(negedge clk);
    chk("lb_req", dmem_req, 32'd1);
    chk("lb_we", dmem_we, 32'd0);
    chk("lb_be", dmem_be, 32'b0100);
    chk("lb_stall_c0", stall_MEM, 32'd1);
    cyc();
    dmem_gnt = 1'b0;
    chk("lb_bubble", regwrite_WB, 32'd0);
    @(negedge clk);
    chk("lb_stall_c1", stall_MEM, 32'd1);
    chk("lb_req_wait", dmem_req, 32'd0);
    cyc();
    @(negedge clk);
    chk("lb_stall_c2", stall_MEM, 32'd1);
    cyc();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0080_0000;
    @(negedge clk);
    chk("lb_stall_c3", stall_MEM, 32'd0);
    cyc();
    dmem_rvalid = 1'b0;
    chk("lb_wb_data", wb_data_WB, 32'hFFFF_FF80);
    chk("lb_regwrite_wb", regwrite_WB, 32'd1);
    chk("lb_rd_wb", rd_WB, 32'd7);

    // ---- LBU at 0x102 with gnt and rvalid together in IDLE (rvalid ignored)
    drive(1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_0102, 32'h0, 3'b100);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("lbu_stall_c0", stall_MEM, 32'd1);
    cyc();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("lbu_stall_c1", stall_MEM, 32'd1);
    cyc();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0080_0000;
    @(negedge clk);
    chk("lbu_stall_c2", stall_MEM, 32'd0);
    cyc();
    dmem_rvalid = 1'b0;
    chk("lbu_wb_data", wb_data_WB, 32'h0000_0080);
    chk("lbu_rd_wb", rd_WB, 32'd8);

    // ---- LH at 0x302: upper half, sign-extended
    drive(1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_0302, 32'h0, 3'b001);
    dmem_gnt = 1'b1;
    @(negedge clk);
    chk("lh_be", dmem_be, 32'b1100);
    cyc();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF_1234;
    cyc();
    dmem_rvalid = 1'b0;
    chk("lh_wb_data", wb_data_WB, 32'hFFFF_BEEF);

    // ---- LW at 0x202: misaligned, no request, no stall, regwrite squashed
    drive(1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0202, 32'h0, 3'b010);
    @(negedge clk);
    chk("lw_mis_flag", misalign_MEM, 32'd1);
    chk("lw_mis_req", dmem_req, 32'd0);
    chk("lw_mis_stall", stall_MEM, 32'd0);
    cyc();
    chk("lw_mis_regwrite_wb", regwrite_WB, 32'd0);
    chk("lw_mis_rd_wb", rd_WB, 32'd9);

    // ---- SW at 0x400 with gnt withheld for 2 cycles
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0400, 32'hDEAD_BEEF, 3'b010);
    dmem_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("sw_wait_req", dmem_req, 32'd1);
      chk("sw_wait_stall", stall_MEM, 32'd1);
      chk("sw_wait_addr", dmem_addr, 32'h0000_0400);
      chk("sw_wait_wdata", dmem_wdata, 32'hDEAD_BEEF);
      cyc();
    end
    dmem_gnt = 1'b1;
    @(negedge clk);
    chk("sw_gnt_req", dmem_req, 32'd1);
    chk("sw_gnt_be", dmem_be, 32'b1111);
    chk("sw_gnt_stall", stall_MEM, 32'd0);
    cyc();
    dmem_gnt = 1'b0;
    chk("sw_regwrite_wb", regwrite_WB, 32'd0);

    // ---- reset during WAIT, then a late rvalid
    drive(1'b1, 1'b0, 1'b1, 5'd11, 32'h0000_0500, 32'h0, 3'b010);
    dmem_gnt = 1'b1;
    cyc();
    dmem_gnt = 1'b0;
    @(negedge clk);
    chk("rw_in_wait", stall_MEM, 32'd1);
    cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("rw_rst_stall", stall_MEM, 32'd0);
    chk("rw_rst_req", dmem_req, 32'd0);
    cyc();
    reset = 1'b0; nop(); dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("rw_late_stall", stall_MEM, 32'd0);
    chk("rw_late_req", dmem_req, 32'd0);
    cyc();
    dmem_rvalid = 1'b0;
    chk("rw_regwrite_wb", regwrite_WB, 32'd0);
    // a stuck WAIT would stall here and suppress the request
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0600, 32'h0000_00CD, 3'b000);
    dmem_gnt = 1'b1;
    @(negedge clk);
    chk("rw_idle_stall", stall_MEM, 32'd0);
    chk("rw_idle_req", dmem_req, 32'd1);
    cyc();
    dmem_gnt = 1'b0; nop();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-stage consumer of the EX/MEM pipeline register: takes the latched load/store control, ALU address and store data, runs a req/gnt/rvalid handshake with the data memory, and aligns and extends load data. It also stalls the pipeline while an access is outstanding and registers the MEM/WB pipeline outputs (regwrite, rd, write-back data). It sits between the EX/MEM register and the writeback stage / register file.

## Interface
Parameters:
- None; data and address widths are fixed at 32 bits.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- memread_MEM  in  1  load in MEM stage
- memwrite_MEM  in  1  store in MEM stage
- regwrite_MEM  in  1  instruction writes rd
- rd_MEM  in  5  destination register
- ALU_data_MEM  in  32  ALU result; byte address for loads/stores
- store_data_MEM  in  32  rs2 value for stores
- funct3_MEM  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- dmem_req  out  1  access request, held until dmem_gnt
- dmem_we  out  1  1 = write
- dmem_addr  out  32  {ALU_data_MEM[31:2], 2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  memory accepted request this cycle
- dmem_rvalid  in  1  read data valid this cycle
- dmem_rdata  in  32  read word
- stall_MEM  out  1  freeze IF..EX/MEM; upstream holds the *_MEM inputs stable
- misalign_MEM  out  1  misaligned access flagged this cycle
- regwrite_WB  out  1  registered write enable to the register file
- rd_WB  out  5  registered destination
- wb_data_WB  out  32  registered write-back data

## Operation
- FSM states: IDLE, WAIT. Reset → IDLE.
- access = (memread_MEM | memwrite_MEM) & ~misalign. If memread and memwrite are both high, treat it as a read and ignore memwrite.
- Misaligned conditions:
  - H/HU with addr[0] = 1
  - W with addr[1:0] ≠ 0
  - On a misaligned access: no request, misalign_MEM = 1 combinationally, no stall, regwrite_WB written 0.
- IDLE:
  - dmem_req = access; dmem_we = memwrite & ~memread.
  - On dmem_gnt with a write: the store completes and there is no stall that cycle.
  - On dmem_gnt with a read: go to WAIT.
  - Without gnt: stay in IDLE, stall_MEM = 1, request held.
- WAIT:
  - dmem_req = 0; stall_MEM = ~dmem_rvalid.
  - On dmem_rvalid: capture the load result and return to IDLE.
- stall_MEM = (IDLE & access & ~(gnt & write)) | (WAIT & ~rvalid).
- dmem_rvalid is ignored in IDLE.
- Byte enables and store data:
  - B: be = 0001 << addr[1:0]; wdata = {4{sd[7:0]}}
  - H: be = 0011 << addr[1:0]; wdata = {2{sd[15:0]}}
  - W: be = 1111; wdata = sd
  - Loads drive be per the same rule.
- Load extract: select the byte/half at addr[1:0] from dmem_rdata. B/H sign-extend; BU/HU zero-extend; W passes through.
- MEM/WB register, updated every clock:
  - When stall_MEM = 1: regwrite_WB <= 0 (bubble); rd_WB and wb_data_WB hold.
  - Otherwise: regwrite_WB <= regwrite_MEM & ~misalign; rd_WB <= rd_MEM; wb_data_WB <= memread ? extracted load : ALU_data_MEM.

## Timing
- Reset values: regwrite_WB 0, rd_WB 0, wb_data_WB 0, FSM IDLE. dmem_req, stall_MEM and misalign_MEM are forced 0 while reset is high.
- Reset mid-access (IDLE with req pending, or WAIT) aborts to IDLE. A late rvalid after reset is ignored.
- Non-memory instruction: written to MEM/WB on the next edge, 1-cycle latency, no stall.
- Store:
  - Zero-wait gnt: one cycle in MEM, no stall.
  - Each cycle without gnt adds one stall cycle.
- Load:
  - Minimum 2 cycles in MEM (gnt cycle, then rvalid cycle ≥1 later).
  - Stall is high from the request cycle through the cycle before rvalid.
  - wb_data_WB is valid the edge after rvalid.
- gnt and rvalid in the same cycle while in IDLE: rvalid is ignored; the FSM enters WAIT and waits for a later rvalid.

## Test plan
- Reset during WAIT, then rvalid = 1 the following cycle → FSM IDLE, regwrite_WB = 0, no stall, no req.
- ALU op: regwrite=1, rd=5, ALU_data=0x1234 → next edge regwrite_WB=1, rd_WB=5, wb_data_WB=0x1234; stall_MEM never high.
- SB: addr 0x103, sd 0xAB, gnt same cycle → be=1000, wdata=0xABABABAB, dmem_addr=0x100, stall_MEM=0, regwrite_WB=0.
- LB: addr 0x102, gnt in cycle 0, rdata=0x0080_0000 with rvalid in cycle 3 → stall_MEM high cycles 0–2, wb_data_WB=0xFFFFFF80. Repeat as LBU → 0x00000080.
- LW at 0x202 → misalign_MEM=1, dmem_req=0, stall_MEM=0, regwrite_WB=0 next edge.
- SW with gnt withheld 2 cycles → dmem_req and stall_MEM high for 2 cycles with stable addr/wdata; completes on the 3rd cycle.
